// File: rtl/syncfifo_ptr_ctrl.sv
// Pointer and flag controller for a synchronous FIFO of DEPTH entries.
// The storage array is external. This block supplies the write and read
// addresses, the qualified push and pop strobes, the occupancy count, the
// status flags and two sticky error flags.
//
// Handshake: wen/ren are requests. push/pop are the granted strobes for the
// current cycle. Storage must write at w_addr when push=1. The head entry
// is always presented at r_addr, and pop=1 means it is consumed on this edge.
module syncfifo_ptr_ctrl #(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int ADDR_W  = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wen,
  input  logic              ren,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] r_addr,
  output logic              push,
  output logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  AF_C      = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  AE_C      = CNT_W'(AE_LEVEL);

  // Pointer layout: {wrap, address}. The wrap bit tells full from empty
  // when the two addresses are equal.
  logic [ADDR_W:0]  w_ptr_q, w_ptr_d;
  logic [ADDR_W:0]  r_ptr_q, r_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  // The address wraps at DEPTH-1, which need not be a power of two, and
  // the wrap bit toggles on that wrap.
  function automatic logic [ADDR_W:0] ptr_inc(input logic [ADDR_W:0] p);
    logic [ADDR_W:0] r;
    if (p[ADDR_W-1:0] == LAST_ADDR) begin
      r = {~p[ADDR_W], {ADDR_W{1'b0}}};
    end else begin
      r = {p[ADDR_W], p[ADDR_W-1:0] + ADDR_W'(1)};
    end
    return r;
  endfunction

  // Derive the flags and strobes from registered state only. rst_n gates
  // the strobes so that no write is requested while the block is in reset.
  always_comb begin
    empty        = (w_ptr_q == r_ptr_q);
    full         = (w_ptr_q[ADDR_W-1:0] == r_ptr_q[ADDR_W-1:0]) &&
                   (w_ptr_q[ADDR_W] != r_ptr_q[ADDR_W]);
    pop          = rst_n & ren & ~empty & ~clr;
    push         = rst_n & wen & ~clr & (~full | pop);
    w_addr       = w_ptr_q[ADDR_W-1:0];
    r_addr       = r_ptr_q[ADDR_W-1:0];
    count        = count_q;
    almost_full  = (count_q >= AF_C);
    almost_empty = (count_q <= AE_C);
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  // Compute the next state. clr flushes everything, and the error flags
  // otherwise stick once they are set.
  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      w_ptr_d     = '0;
      r_ptr_d     = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push) w_ptr_d = ptr_inc(w_ptr_q);
      if (pop)  r_ptr_d = ptr_inc(r_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (wen && !push) overflow_d  = 1'b1;
      if (ren && !pop)  underflow_d = 1'b1;
    end
  end

  // State registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_syncfifo_ptr_ctrl.sv
// Bench for syncfifo_ptr_ctrl. Two instances are built: "a" with DEPTH=5
// and default levels, and "b" with DEPTH=8, AF_LEVEL=6 and AE_LEVEL=2.
// A model tracks each instance as an occupancy count plus head and tail
// indices modulo DEPTH. Directed sequences also check literal values.
module tb_syncfifo_ptr_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT a: DEPTH=5 ----------------
  logic       clr_a = 0, wen_a = 0, ren_a = 0;
  logic [2:0] w_addr_a, r_addr_a, count_a;
  logic       push_a, pop_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;

  syncfifo_ptr_ctrl #(.DEPTH(5)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .wen(wen_a), .ren(ren_a),
    .w_addr(w_addr_a), .r_addr(r_addr_a), .push(push_a), .pop(pop_a),
    .count(count_a), .full(full_a), .empty(empty_a),
    .almost_full(af_a), .almost_empty(ae_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  // ---------------- DUT b: DEPTH=8, AF=6, AE=2 ----------------
  logic       clr_b = 0, wen_b = 0, ren_b = 0;
  logic [2:0] w_addr_b, r_addr_b;
  logic [3:0] count_b;
  logic       push_b, pop_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;

  syncfifo_ptr_ctrl #(.DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .wen(wen_b), .ren(ren_b),
    .w_addr(w_addr_b), .r_addr(r_addr_b), .push(push_b), .pop(pop_b),
    .count(count_b), .full(full_b), .empty(empty_b),
    .almost_full(af_b), .almost_empty(ae_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int dep[2] = '{5, 8};
  int afl[2] = '{4, 6};
  int ael[2] = '{1, 2};
  int m_cnt[2] = '{0, 0};
  int m_wa[2]  = '{0, 0};
  int m_ra[2]  = '{0, 0};
  bit m_ovf[2] = '{0, 0};
  bit m_unf[2] = '{0, 0};

  function automatic bit m_pop(input int i, input bit rs, input bit c, input bit r);
    return rs && r && !c && (m_cnt[i] > 0);
  endfunction

  function automatic bit m_push(input int i, input bit rs, input bit c, input bit w, input bit r);
    return rs && w && !c && ((m_cnt[i] < dep[i]) || m_pop(i, rs, c, r));
  endfunction

  task automatic m_upd(input int i, input bit c, input bit w, input bit r);
    bit pu, po;
    pu = m_push(i, 1'b1, c, w, r);
    po = m_pop(i, 1'b1, c, r);
    if (c) begin
      m_cnt[i] = 0; m_wa[i] = 0; m_ra[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    end else begin
      if (pu) m_wa[i] = (m_wa[i] + 1) % dep[i];
      if (po) m_ra[i] = (m_ra[i] + 1) % dep[i];
      m_cnt[i] = m_cnt[i] + int'(pu) - int'(po);
      if (w && !pu) m_ovf[i] = 1;
      if (r && !po) m_unf[i] = 1;
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_wa[i] = 0; m_ra[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else begin
      m_upd(0, clr_a, wen_a, ren_a);
      m_upd(1, clr_b, wen_b, ren_b);
    end
  end

  // ---------------- per-cycle compare (mid-cycle, on negedge) ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a.w_addr", int'(w_addr_a), m_wa[0]);
      cmp("a.r_addr", int'(r_addr_a), m_ra[0]);
      cmp("a.count",  int'(count_a),  m_cnt[0]);
      cmp("a.push",   int'(push_a),   int'(m_push(0, rst_n, clr_a, wen_a, ren_a)));
      cmp("a.pop",    int'(pop_a),    int'(m_pop(0, rst_n, clr_a, ren_a)));
      cmp("a.full",   int'(full_a),   int'(m_cnt[0] == dep[0]));
      cmp("a.empty",  int'(empty_a),  int'(m_cnt[0] == 0));
      cmp("a.af",     int'(af_a),     int'(m_cnt[0] >= afl[0]));
      cmp("a.ae",     int'(ae_a),     int'(m_cnt[0] <= ael[0]));
      cmp("a.ovf",    int'(ovf_a),    int'(m_ovf[0]));
      cmp("a.unf",    int'(unf_a),    int'(m_unf[0]));
      cmp("b.w_addr", int'(w_addr_b), m_wa[1]);
      cmp("b.r_addr", int'(r_addr_b), m_ra[1]);
      cmp("b.count",  int'(count_b),  m_cnt[1]);
      cmp("b.push",   int'(push_b),   int'(m_push(1, rst_n, clr_b, wen_b, ren_b)));
      cmp("b.pop",    int'(pop_b),    int'(m_pop(1, rst_n, clr_b, ren_b)));
      cmp("b.full",   int'(full_b),   int'(m_cnt[1] == dep[1]));
      cmp("b.empty",  int'(empty_b),  int'(m_cnt[1] == 0));
      cmp("b.af",     int'(af_b),     int'(m_cnt[1] >= afl[1]));
      cmp("b.ae",     int'(ae_b),     int'(m_cnt[1] <= ael[1]));
      cmp("b.ovf",    int'(ovf_b),    int'(m_ovf[1]));
      cmp("b.unf",    int'(unf_b),    int'(m_unf[1]));
    end
  end

  // ---------------- driver ----------------
  bit lp_push, lp_pop;  // strobes seen mid-cycle during the last step

  // One clock cycle on instance i. Called shortly after a rising edge;
  // returns 2 time units after the next rising edge with inputs idle.
  task automatic step(input int i, input bit c, input bit w, input bit r);
    if (i == 0) begin clr_a = c; wen_a = w; ren_a = r; end
    else        begin clr_b = c; wen_b = w; ren_b = r; end
    @(negedge clk);
    lp_push = (i == 0) ? push_a : push_b;
    lp_pop  = (i == 0) ? pop_a  : pop_b;
    @(posedge clk);
    #1;
    clr_a = 0; wen_a = 0; ren_a = 0;
    clr_b = 0; wen_b = 0; ren_b = 0;
    #1;
  endtask

  // Mixed directed vectors for instance a: {clr, wen, ren}.
  logic [2:0] mix_tab [12] = '{3'b010, 3'b010, 3'b011, 3'b001, 3'b001,
                               3'b001, 3'b010, 3'b111, 3'b010, 3'b011,
                               3'b100, 3'b001};

  // ---------------- directed stimulus ----------------
  initial begin
    #2 rst_n = 0;
    #1 chk_en = 1;
    // Reset state, taken between edges.
    cmp("rst.count", int'(count_a), 0);
    cmp("rst.empty", int'(empty_a), 1);
    cmp("rst.full",  int'(full_a),  0);
    cmp("rst.af",    int'(af_a),    0);
    cmp("rst.ae",    int'(ae_a),    1);
    wen_a = 1; #1;
    cmp("rst.push_gated", int'(push_a), 0);
    wen_a = 0;
    #19 rst_n = 1;           // released at t=23, away from any edge
    @(posedge clk); #1;

    // Five pushes into DEPTH=5, then an overflowing sixth.
    for (int k = 0; k < 5; k++) begin
      cmp("fill.w_addr", int'(w_addr_a), k);
      step(0, 0, 1, 0);
      cmp("fill.count", int'(count_a), k + 1);
    end
    cmp("fill.w_addr_wrap", int'(w_addr_a), 0);
    cmp("fill.full", int'(full_a), 1);
    step(0, 0, 1, 0);
    cmp("ovf.push", int'(lp_push), 0);
    cmp("ovf.flag", int'(ovf_a), 1);
    cmp("ovf.count", int'(count_a), 5);

    // Simultaneous push and pop while full.
    for (int k = 0; k < 3; k++) begin
      cmp("pp.r_addr", int'(r_addr_a), k);
      step(0, 0, 1, 1);
      cmp("pp.push", int'(lp_push), 1);
      cmp("pp.pop",  int'(lp_pop), 1);
      cmp("pp.count", int'(count_a), 5);
      cmp("pp.full", int'(full_a), 1);
    end
    cmp("pp.r_addr_end", int'(r_addr_a), 3);

    // Drain to 3 entries, then clear with wen and ren also asserted.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    cmp("pre_clr.count", int'(count_a), 3);
    cmp("pre_clr.ovf", int'(ovf_a), 1);
    step(0, 1, 1, 1);
    cmp("clr.push", int'(lp_push), 0);
    cmp("clr.pop",  int'(lp_pop), 0);
    cmp("clr.count", int'(count_a), 0);
    cmp("clr.w_addr", int'(w_addr_a), 0);
    cmp("clr.r_addr", int'(r_addr_a), 0);
    cmp("clr.ovf", int'(ovf_a), 0);

    // Empty FIFO with wen and ren together: the pop is not granted.
    step(0, 0, 1, 1);
    cmp("ew.push", int'(lp_push), 1);
    cmp("ew.pop",  int'(lp_pop), 0);
    cmp("ew.unf",  int'(unf_a), 1);
    cmp("ew.count", int'(count_a), 1);
    step(0, 0, 0, 1);
    cmp("ew.pop2", int'(lp_pop), 1);
    cmp("ew.empty", int'(empty_a), 1);

    // Instance b: move the pointers to 3, then fill and drain across the wrap.
    for (int k = 0; k < 3; k++) step(1, 0, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 1);
    for (int c = 0; c < 8; c++) begin
      cmp("b.fill.ae", int'(ae_b), int'(c <= 2));
      cmp("b.fill.af", int'(af_b), int'(c >= 6));
      step(1, 0, 1, 0);
    end
    cmp("b.full8", int'(full_b), 1);
    cmp("b.count8", int'(count_b), 8);
    cmp("b.af8", int'(af_b), 1);
    for (int c = 8; c > 0; c--) begin
      step(1, 0, 0, 1);
      cmp("b.drain.ae", int'(ae_b), int'(c - 1 <= 2));
      cmp("b.drain.af", int'(af_b), int'(c - 1 >= 6));
    end
    cmp("b.end.count", int'(count_b), 0);
    cmp("b.end.empty", int'(empty_b), 1);
    cmp("b.end.r_addr", int'(r_addr_b), 3);
    cmp("b.end.w_addr", int'(w_addr_b), 3);

    // Mixed vectors on instance a; the model checks every cycle.
    for (int k = 0; k < 12; k++) begin
      logic [2:0] v;
      v = mix_tab[k];
      step(0, v[2], v[1], v[0]);
    end
    step(0, 1, 0, 0);

    // Reset dropped mid-operation at count 4.
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0);
    cmp("mr.count4", int'(count_a), 4);
    #1 rst_n = 0;
    #1;
    cmp("mr.count", int'(count_a), 0);
    cmp("mr.empty", int'(empty_a), 1);
    #3 rst_n = 1;
    @(posedge clk); #1;
    step(0, 0, 1, 0);
    cmp("mr.push_count", int'(count_a), 1);
    cmp("mr.push_waddr", int'(w_addr_a), 1);

    @(posedge clk); #1;
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/syncfifo_ptr_ctrl.md
SYNCFIFO_PTR_CTRL -- requirements
Module: syncfifo_ptr_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of FIFO entries; any integer >= 2, power of two not required.
REQ-002 SHALL have parameter AF_LEVEL, default DEPTH-1, meaning count at or above which almost_full asserts; range 1..DEPTH.
REQ-003 SHALL have parameter AE_LEVEL, default 1, meaning count at or below which almost_empty asserts; range 0..DEPTH-1.
REQ-004 SHALL have derived localparams ADDR_W = max(1, clog2(DEPTH)) and CNT_W = clog2(DEPTH+1).
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 clr  in  1  synchronous flush; takes priority over wen and ren.
REQ-008 wen  in  1  push request.
REQ-009 ren  in  1  pop request.
REQ-010 w_addr  out  ADDR_W  storage write address for the current cycle.
REQ-011 r_addr  out  ADDR_W  storage read address (head entry).
REQ-012 push  out  1  qualified write strobe to storage.
REQ-013 pop  out  1  qualified read-advance strobe.
REQ-014 count  out  CNT_W  current occupancy, 0..DEPTH.
REQ-015 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-016 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-017 Internal w_ptr and r_ptr SHALL each be an ADDR_W address plus 1 wrap bit; at address DEPTH-1 an increment SHALL go to address 0 and toggle the wrap bit.
REQ-018 empty SHALL be (w_ptr == r_ptr); full SHALL be (addresses equal and wrap bits differ); both combinational from registered state.
REQ-019 pop SHALL be ren & ~empty & ~clr (no write-through bypass when empty).
REQ-020 push SHALL be wen & ~clr & (~full | pop), so a simultaneous pop on a full FIFO admits the push.
REQ-021 On each edge, r_ptr SHALL advance by 1 if pop and w_ptr by 1 if push; count SHALL change by push - pop (net 0 when both).
REQ-022 count SHALL be a register consistent with the pointers at all times; full iff count == DEPTH, empty iff count == 0.
REQ-023 almost_full SHALL be (count >= AF_LEVEL); almost_empty SHALL be (count <= AE_LEVEL); combinational from count.
REQ-024 w_addr and r_addr SHALL be the address fields of w_ptr and r_ptr; no added latency; the popped entry is at r_addr during the pop cycle.
REQ-025 overflow SHALL set on any cycle with wen & ~push & ~clr, and underflow on any cycle with ren & ~pop & ~clr; both hold until clr or reset.
REQ-026 clr SHALL on the next edge zero both pointers, count, overflow and underflow, and assert no push/pop in its cycle.
REQ-027 Push/pop SHALL commit no state change other than as specified; idle cycles hold all state.

Reset
REQ-028 While rst_n = 0, pointers, count, overflow and underflow SHALL be 0 immediately, independent of clk: empty = 1, almost_empty = 1 (AE_LEVEL >= 0), full = 0, almost_full = 0, push = pop = 0.
REQ-029 Reset asserted mid-operation SHALL discard all occupancy; the first edge after rst_n rises SHALL accept a push normally.

Verification
REQ-030 DEPTH=5: 5 pushes -> count 1..5, w_addr 0,1,2,3,4 then 0, full=1 after 5th; 6th wen -> push=0, overflow=1, count stays 5.
REQ-031 DEPTH=5 full: wen=ren=1 for 3 cycles -> push=pop=1 each cycle, count stays 5, r_addr 0->1->2->3, full held.
REQ-032 Empty FIFO: wen=ren=1 -> push=1, pop=0, underflow=1, count 0->1; next cycle ren only -> pop=1, empty=1.
REQ-033 DEPTH=8, AF_LEVEL=6, AE_LEVEL=2: fill 0->8 and drain -> almost_empty at counts 0..2, almost_full at 6..8; 8 pushes and 8 pops across a wrap give count 0, empty=1.
REQ-034 Count 3 with overflow set: clr with wen=ren=1 -> push=pop=0; next edge count 0, pointers 0, overflow 0.
REQ-035 Drop rst_n between edges at count 4 -> count 0, empty=1 before next edge; release and push -> count 1, w_addr 1.
